// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: ROM, datapath and data-memory handshake signals of the fetch/execute sequencer.
// RetireCount is present only when PC_SEQ_RETIRE_COUNT_EN is defined.
interface pc_sequencer_if #(
    parameter int unsigned PC_WIDTH   = 8,
    parameter int unsigned INST_WIDTH = 10
);
    logic                  Start;
    logic [PC_WIDTH-1:0]   InstAddress;
    logic [INST_WIDTH-1:0] InstIn;
    logic [INST_WIDTH-1:0] InstReg;
    logic                  ExecValid;
    logic                  EqFlag;
    logic                  MemRead;
    logic                  MemWrite;
    logic                  MemAck;
    logic                  Halted;
`ifdef PC_SEQ_RETIRE_COUNT_EN
    logic [15:0]           RetireCount;
`endif

    // Sequencer side
    modport master (
        input  Start, InstIn, EqFlag, MemAck,
        output InstAddress, InstReg, ExecValid, MemRead, MemWrite, Halted
`ifdef PC_SEQ_RETIRE_COUNT_EN
        , output RetireCount
`endif
    );

    // ROM / datapath / memory side
    modport slave (
        output Start, InstIn, EqFlag, MemAck,
        input  InstAddress, InstReg, ExecValid, MemRead, MemWrite, Halted
`ifdef PC_SEQ_RETIRE_COUNT_EN
        , input RetireCount
`endif
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute sequencer for the 10-bit CPU. Owns the PC, latches the
// fetched word, resolves jump/beq/bne and runs the data-memory request handshake.
// Optional feature macro: PC_SEQ_RETIRE_COUNT_EN adds a saturating 16-bit RetireCount.
module pc_sequencer #(
    parameter int unsigned PC_WIDTH   = 8,
    parameter int unsigned INST_WIDTH = 10,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    pc_sequencer_if.master        bus
);

    localparam int unsigned OP_WIDTH = 4;
    localparam int unsigned JMP_WIDTH = 6;

    localparam logic [OP_WIDTH-1:0] OP_HALT  = 4'b0000;
    localparam logic [OP_WIDTH-1:0] OP_JUMP  = 4'b1001;
    localparam logic [OP_WIDTH-1:0] OP_BEQ   = 4'b1000;
    localparam logic [OP_WIDTH-1:0] OP_BNE   = 4'b1100;
    localparam logic [OP_WIDTH-1:0] OP_LOAD  = 4'b0110;
    localparam logic [OP_WIDTH-1:0] OP_STORE = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_e;

    state_e                state_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [INST_WIDTH-1:0] inst_q;
    logic                  exec_valid_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic                  halted_q;

    logic [OP_WIDTH-1:0]   opcode;
    logic [PC_WIDTH-1:0]   pc_inc1;
    logic [PC_WIDTH-1:0]   pc_inc2;
    logic [PC_WIDTH-1:0]   jump_target;

    // Decode fields and candidate next-PC values; sums wrap at 2^PC_WIDTH
    assign opcode      = inst_q[INST_WIDTH-1 -: OP_WIDTH];
    assign pc_inc1     = pc_q + PC_WIDTH'(1);
    assign pc_inc2     = pc_q + PC_WIDTH'(2);
    assign jump_target = PC_WIDTH'(inst_q[JMP_WIDTH-1:0]);

    // Sequencer FSM with registered PC, instruction and control outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            pc_q         <= PC_WIDTH'(RESET_PC);
            inst_q       <= '0;
            exec_valid_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            exec_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.Start) begin
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    inst_q  <= bus.InstIn;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    case (opcode)
                        OP_HALT: begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end
                        OP_JUMP: begin
                            pc_q         <= jump_target;
                            exec_valid_q <= 1'b1;
                            state_q      <= S_FETCH;
                        end
                        // Conditional skip: a true condition falls through, false skips one
                        OP_BEQ: begin
                            pc_q         <= bus.EqFlag ? pc_inc1 : pc_inc2;
                            exec_valid_q <= 1'b1;
                            state_q      <= S_FETCH;
                        end
                        OP_BNE: begin
                            pc_q         <= bus.EqFlag ? pc_inc2 : pc_inc1;
                            exec_valid_q <= 1'b1;
                            state_q      <= S_FETCH;
                        end
                        OP_LOAD: begin
                            mem_read_q <= 1'b1;
                            state_q    <= S_MEM;
                        end
                        OP_STORE: begin
                            mem_write_q <= 1'b1;
                            state_q     <= S_MEM;
                        end
                        default: begin
                            pc_q         <= pc_inc1;
                            exec_valid_q <= 1'b1;
                            state_q      <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (bus.MemAck) begin
                        exec_valid_q <= 1'b1;
                        mem_read_q   <= 1'b0;
                        mem_write_q  <= 1'b0;
                        pc_q         <= pc_inc1;
                        state_q      <= S_FETCH;
                    end
                end
                S_HALT: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.InstAddress = pc_q;
    assign bus.InstReg     = inst_q;
    assign bus.ExecValid   = exec_valid_q;
    assign bus.MemRead     = mem_read_q;
    assign bus.MemWrite    = mem_write_q;
    assign bus.Halted      = halted_q;

`ifdef PC_SEQ_RETIRE_COUNT_EN
    logic [15:0] retire_cnt_q;

    // Count retired instructions, one per ExecValid pulse, saturating at all-ones
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            retire_cnt_q <= '0;
        end else if (exec_valid_q && (retire_cnt_q != 16'hFFFF)) begin
            retire_cnt_q <= retire_cnt_q + 16'd1;
        end
    end

    assign bus.RetireCount = retire_cnt_q;
`endif

endmodule
